// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port request/grant arbiter sequencing accesses to a single-port data memory
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin tie-break; fixed port-0 priority when undefined)
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic req_any;
  logic winner;      // 0 = port 0, 1 = port 1
  logic sel_we;
  logic take_cmd;    // a command is accepted at this edge
  logic owner;       // port that owns the command in flight

  assign req_any = req0 | req1;
  assign sel_we  = winner ? we1 : we0;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port not granted last wins; a lone requester always wins
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last_grant;
    end
  end

  // Remember which port was granted most recently; reset favours port 0
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (take_cmd) begin
      last_grant <= winner;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting
  always_comb begin
    winner = ~req0;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and combinational outputs; requests are only looked at in IDLE
  always_comb begin
    state_next   = state;
    take_cmd     = 1'b0;
    busy         = (state != IDLE);
    mem_write_en = (state == WRITE) && !reset;
    case (state)
      IDLE: begin
        if (req_any) begin
          take_cmd   = 1'b1;
          state_next = sel_we ? WRITE : READ;
        end
      end
      WRITE:   state_next = IDLE;
      READ:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command latch, grant/response pulses and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata       <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      owner       <= 1'b0;
    end else begin
      gnt0    <= take_cmd && !winner;
      gnt1    <= take_cmd && winner;
      rvalid0 <= (state == READ) && !owner;
      rvalid1 <= (state == READ) && owner;
      if (take_cmd) begin
        owner       <= winner;
        mem_address <= winner ? addr1 : addr0;
        mem_data_in <= winner ? wdata1 : wdata0;
      end
      if (state == READ) begin
        rdata <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter with a transaction-level model
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, mem_write_en;
  logic [7:0]  rdata, mem_data_in;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_out = '0;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents not yet written read as a fixed pattern of the address
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Device memory driven only by the DUT's memory port
  logic [7:0] dev_mem [logic [15:0]];
  always @(posedge clk) begin
    if (mem_write_en) dev_mem[mem_address] = mem_data_in;
  end
  always @(negedge clk) begin
    mem_data_out = dev_mem.exists(mem_address) ? dev_mem[mem_address] : init_val(mem_address);
  end

  // Reference model: one accepted command occupies the following cycle
  logic [7:0]  ref_mem [logic [15:0]];
  bit          started = 0;
  bit          m_busy = 0, m_we = 0, m_owner = 0, m_last = 1, win;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0, e_rdata = '0;
  bit          e_gnt0 = 0, e_gnt1 = 0, e_rv0 = 0, e_rv1 = 0;

  always @(posedge clk) begin
    started = 1;
    e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0;
    if (reset) begin
      m_busy = 0; m_we = 0; m_owner = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; e_rdata = '0;
    end else if (m_busy) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else begin
        e_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
        if (m_owner) e_rv1 = 1; else e_rv0 = 1;
      end
      m_busy = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        win = (m_last == 0);
`else
        win = 0;
`endif
      end else begin
        win = req1;
      end
      m_owner = win;
      m_we    = win ? we1 : we0;
      m_addr  = win ? addr1 : addr0;
      m_wdata = win ? wdata1 : wdata0;
      m_last  = win;
      if (win) e_gnt1 = 1; else e_gnt0 = 1;
      m_busy = 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  bit prev_busy = 0;
  always @(negedge clk) begin
    if (started) begin
      check("gnt0", gnt0, e_gnt0);
      check("gnt1", gnt1, e_gnt1);
      check("rvalid0", rvalid0, e_rv0);
      check("rvalid1", rvalid1, e_rv1);
      check("rdata", rdata, e_rdata);
      check("busy", busy, m_busy);
      check("mem_write_en", mem_write_en, m_busy && m_we && !reset);
      check("mem_address", mem_address, m_addr);
      check("mem_data_in", mem_data_in, m_wdata);
      if (gnt0 || gnt1) check("gnt_after_busy", prev_busy, 0);
      prev_busy = busy;
    end
  end

  // Present a command and return in the cycle its grant is expected
  task automatic issue(input bit port, input bit we, input logic [15:0] a, input logic [7:0] d);
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    @(posedge clk);
    @(negedge clk);
  endtask

  int grants[$];
  int exp_order[4];

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_gnt0", gnt0, 0);
    check("reset_addr", mem_address, 0);
    check("reset_rdata", rdata, 0);
    @(posedge clk); #2;
    reset = 0;

    // Port 0 write 25 to address 2
    issue(0, 1, 16'd2, 8'd25);
    check("wr_gnt0", gnt0, 1);
    check("wr_we", mem_write_en, 1);
    check("wr_addr", mem_address, 2);
    check("wr_data", mem_data_in, 25);
    check("wr_busy", busy, 1);
    @(posedge clk); #2;
    req0 = 0;
    @(negedge clk);
    check("wr_busy_done", busy, 0);

    // Port 1 read of address 2
    issue(1, 0, 16'd2, 8'd0);
    check("rd_gnt1", gnt1, 1);
    @(posedge clk); #2;
    req1 = 0;
    @(negedge clk);
    check("rd_rvalid1", rvalid1, 1);
    check("rd_rvalid0", rvalid0, 0);
    check("rd_rdata", rdata, 25);

    // Tie: port 0 writes 50 to address 5, port 1 reads address 5, both held
    @(posedge clk); #2;
    req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 8'd50;
    req1 = 1; we1 = 0; addr1 = 16'd5;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    grants.delete();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (gnt0) grants.push_back(0);
      if (gnt1) grants.push_back(1);
      if (rvalid1) check("tie_rdata", rdata, 50);
    end
    check("tie_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("tie_order", grants[i], exp_order[i]);
    @(posedge clk); #2;
    req0 = 0; req1 = 0;
    repeat (3) @(posedge clk);
    #2;

    // Reset during a write of 99 to address 7 suppresses it
    issue(0, 1, 16'd7, 8'd99);
    #1;
    reset = 1; req0 = 0;
    #1;
    check("rst_wr_gated", mem_write_en, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_out", {gnt0, gnt1, rvalid0, rvalid1, busy, mem_write_en}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data_in, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #2;
    reset = 0;
    issue(1, 0, 16'd7, 8'd0);
    @(posedge clk); #2;
    req1 = 0;
    @(negedge clk);
    check("rst_rd_valid", rvalid1, 1);
    check("rst_rd_old", rdata, 8'h5D);

    // Randomised traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 79) == 0);
      if (!req0 || gnt0) begin
        if ($urandom_range(0, 99) < 45) begin
          req0 = 1; we0 = 1'($urandom_range(0, 1));
          addr0 = 16'($urandom_range(0, 15)); wdata0 = 8'($urandom_range(0, 255));
        end else req0 = 0;
      end
      if (!req1 || gnt1) begin
        if ($urandom_range(0, 99) < 45) begin
          req1 = 1; we1 = 1'($urandom_range(0, 1));
          addr1 = 16'($urandom_range(0, 15)); wdata1 = 8'($urandom_range(0, 255));
        end else req1 = 0;
      end
    end
    @(posedge clk); #2;
    reset = 0; req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
